// File: rtl/pe_mult_seq.sv
// Sequential shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per cycle and
// produces the full 2*WIDTH-bit product, unsigned or two's-complement per transaction.
module pe_mult_seq #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mult,
  output logic                 busy
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW   = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e                    state_q, state_d;
  logic [PW-1:0]             mcand_q, mcand_d;   // |a|, pre-shifted to the current bit position
  logic [WIDTH-1:0]          mplier_q, mplier_d; // remaining bits of |b|, LSB first
  logic                      neg_q, neg_d;
  logic [PW-1:0]             acc_q, acc_d;
  logic [PW-1:0]             mult_q, mult_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic [WIDTH-1:0]          a_mag, b_mag;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [PW-1:0]             partial;

  // Magnitudes stay WIDTH-bit unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
  assign a_mag   = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
  assign b_mag   = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
  assign chunk   = mplier_q[BITS_PER_CYCLE-1:0];
  assign partial = mcand_q * PW'(chunk);

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mult_d   = mult_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CntW'(N - 1);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        if (cnt_q == '0) begin
          state_d = StSign;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSign: begin
        mult_d  = neg_q ? (~acc_q) + PW'(1) : acc_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mult_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mult_q   <= mult_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign mult      = mult_q;

endmodule

// File: tb/tb_pe_mult_seq.sv
// Bench for pe_mult_seq: five instances of different WIDTH/BITS_PER_CYCLE share clock and
// reset; directed vectors, back-pressure, mid-operation reset and randomized traffic.
module tb_pe_mult_seq;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv_s [NDUT];
  logic [31:0] a_s  [NDUT];
  logic [31:0] b_s  [NDUT];
  logic        sg_s [NDUT];
  logic        or_s [NDUT];
  logic        ir_s [NDUT];
  logic        ov_s [NDUT];
  logic        bz_s [NDUT];
  logic [63:0] mult_s [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int w_of(input int d);
    return (d < 3) ? 8 : ((d == 3) ? 16 : 32);
  endfunction

  function automatic int b_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 4 : (d == 3) ? 4 : 1;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = (g < 3) ? 8 : ((g == 3) ? 16 : 32);
    localparam int unsigned B = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 4 : 1;
    logic [2*W-1:0] m;
    logic           ir, ov, bz;
    pe_mult_seq #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv_s[g]),
      .in_ready  (ir),
      .a         (a_s[g][W-1:0]),
      .b         (b_s[g][W-1:0]),
      .is_signed (sg_s[g]),
      .out_valid (ov),
      .out_ready (or_s[g]),
      .mult      (m),
      .busy      (bz)
    );
    assign mult_s[g] = 64'(m);
    assign ir_s[g]   = ir;
    assign ov_s[g]   = ov;
    assign bz_s[g]   = bz;
  end

  // Reference: sign-extend to 64 bits, multiply modulo 2^64, keep the low 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input logic s);
    logic [63:0] lo_mask, ea, eb, mask;
    lo_mask = (64'd1 << w) - 64'd1;
    mask    = (w == 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    ea = {32'd0, av} & lo_mask;
    eb = {32'd0, bv} & lo_mask;
    if (s && ea[w-1]) ea = ea | ~lo_mask;
    if (s && eb[w-1]) eb = eb | ~lo_mask;
    return (ea * eb) & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction on instance d; called at #1 after a rising edge with the instance idle.
  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input int hold, output logic [63:0] res,
                        output int lat);
    check($sformatf("d%0d_ready_before", d), 64'(ir_s[d]), 64'd1);
    a_s[d]  = av;
    b_s[d]  = bv;
    sg_s[d] = s;
    iv_s[d] = 1'b1;
    or_s[d] = 1'b0;
    @(posedge clk); #1;
    iv_s[d] = 1'b0;
    // Operands must be captured at the accept edge only.
    a_s[d]  = $urandom;
    b_s[d]  = $urandom;
    sg_s[d] = ~s;
    check($sformatf("d%0d_busy_after_accept", d), 64'({bz_s[d], ir_s[d], ov_s[d]}), 64'b100);
    lat = 0;
    while (!ov_s[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = mult_s[d];
    for (int i = 0; i < hold; i++) begin
      iv_s[d] = 1'($urandom_range(0, 1));
      a_s[d]  = $urandom;
      b_s[d]  = $urandom;
      @(posedge clk); #1;
      check($sformatf("d%0d_hold_state", d), 64'({ov_s[d], ir_s[d]}), 64'b10);
      check($sformatf("d%0d_hold_mult", d), mult_s[d], res);
    end
    iv_s[d] = 1'b0;
    or_s[d] = 1'b1;
    @(posedge clk); #1;
    or_s[d] = 1'b0;
    check($sformatf("d%0d_after_handshake", d), 64'({ov_s[d], ir_s[d], bz_s[d]}), 64'b010);
    check($sformatf("d%0d_mult_retained", d), mult_s[d], res);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl [$];
    logic [63:0] res;
    int          lat;

    tbl.push_back('{0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 9});
    tbl.push_back('{0, 32'h80, 32'h80, 1'b1, 64'h4000, 9});
    tbl.push_back('{0, 32'h80, 32'h01, 1'b1, 64'hFF80, 9});
    tbl.push_back('{0, 32'hFD, 32'h07, 1'b1, 64'hFFEB, 9});
    tbl.push_back('{0, 32'h00, 32'h55, 1'b0, 64'h0000, 9});
    tbl.push_back('{1, 32'hB7, 32'h5C, 1'b0, 64'h41C4, 5});
    tbl.push_back('{1, 32'hB7, 32'h5C, 1'b1, 64'hE5C4, 5});
    tbl.push_back('{2, 32'hB7, 32'h5C, 1'b0, 64'h41C4, 3});
    tbl.push_back('{2, 32'hB7, 32'h5C, 1'b1, 64'hE5C4, 3});
    tbl.push_back('{3, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000, 5});
    tbl.push_back('{3, 32'hFFFF, 32'h0002, 1'b1, 64'hFFFF_FFFE, 5});
    tbl.push_back('{4, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33});
    tbl.push_back('{4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33});

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      iv_s[d] = 1'b0; or_s[d] = 1'b0; sg_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_reset_flags", d), 64'({ir_s[d], ov_s[d], bz_s[d]}), 64'b100);
      check($sformatf("d%0d_reset_mult", d), mult_s[d], 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].s, 0, res, lat);
      check($sformatf("vec%0d_mult", i), res, tbl[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Back-pressure for 20 cycles, then an immediate follow-up transaction.
    run_op(0, 32'h9C, 32'h3B, 1'b0, 20, res, lat);
    check("bp_mult", res, ref_prod(8, 32'h9C, 32'h3B, 1'b0));
    run_op(0, 32'hE1, 32'h0F, 1'b1, 0, res, lat);
    check("bp_next_mult", res, ref_prod(8, 32'hE1, 32'h0F, 1'b1));

    // Reset during the third CALC cycle.
    a_s[0] = 32'h33; b_s[0] = 32'h44; sg_s[0] = 1'b0; iv_s[0] = 1'b1;
    @(posedge clk); #1;
    iv_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_flags", 64'({ir_s[0], ov_s[0], bz_s[0]}), 64'b100);
    check("midreset_mult", mult_s[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 32'h0A, 32'h0B, 1'b0, 0, res, lat);
    check("postreset_mult", res, 64'h006E);
    check("postreset_latency", 64'(lat), 64'd9);

    // Randomized traffic with a scoreboard per instance.
    for (int d = 0; d < NDUT; d++) begin
      logic [63:0] q [$];
      int          acc_cnt = 0;
      int          res_cnt = 0;
      int          guard   = 0;
      while ((acc_cnt < 30 || q.size() > 0) && guard < 20000) begin
        guard++;
        if (acc_cnt < 30) begin
          iv_s[d] = 1'($urandom_range(0, 1));
          a_s[d]  = $urandom;
          b_s[d]  = $urandom;
          sg_s[d] = 1'($urandom_range(0, 1));
        end else begin
          iv_s[d] = 1'b0;
        end
        or_s[d] = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (iv_s[d] && ir_s[d]) begin
          q.push_back(ref_prod(w_of(d), a_s[d], b_s[d], sg_s[d]));
          acc_cnt++;
        end
        if (ov_s[d] && or_s[d]) begin
          res_cnt++;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL d%0d_rand_extra_result: got 0x%0h with no accepted operands",
                     d, mult_s[d]);
          end else begin
            check($sformatf("d%0d_rand_mult", d), mult_s[d], q.pop_front());
          end
        end
        @(posedge clk); #1;
      end
      iv_s[d] = 1'b0;
      or_s[d] = 1'b1;
      check($sformatf("d%0d_rand_drained", d), 64'(q.size()), 64'd0);
      check($sformatf("d%0d_rand_count", d), 64'(res_cnt), 64'(acc_cnt));
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("d%0d_rand_quiet", d), 64'({ov_s[d], ir_s[d]}), 64'b01);
      or_s[d] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
